// File: rtl/pattern_scan_pkg.sv
// pattern_scan_pkg: scanner FSM state type, default widths and counter ceiling
package pattern_scan_pkg;
   typedef enum logic [1:0] {IDLE, LOAD, SCAN, DONE} state_t;
   localparam int DEF_PAT_W = 4;
   localparam int DEF_LEN_W = 8;
   localparam int DEF_CNT_W = 8;
   localparam int DEF_CNT_MAX = (1 << DEF_CNT_W) - 1;
endpackage

// File: rtl/pattern_window.sv
// pattern_window: serial history, fill tracking and masked pattern compare
// PATTERN_OVERLAP_EN keeps fill after a hit so overlapping matches count
module pattern_window #(
   parameter int PAT_W = 4
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         clear,
   input  logic                         shift,
   input  logic                         bit_data,
   input  logic [PAT_W-1:0]             pattern,
   input  logic [$clog2(PAT_W+1)-1:0]   len,
   output logic                         hit
);
   localparam int CL_W = $clog2(PAT_W + 1);
   logic [PAT_W-1:0] history, next_hist, mask;
   logic [PAT_W:0]   ext, one_hot;
   logic [CL_W-1:0]  fill, fill_inc;
   always_comb begin
      ext = {history, bit_data};
      next_hist = ext[PAT_W-1:0];
      one_hot = (PAT_W+1)'(1) << len;
      mask = PAT_W'(one_hot - (PAT_W+1)'(1));
      fill_inc = (fill == CL_W'(PAT_W)) ? fill : fill + CL_W'(1);
      hit = shift && ((CL_W+1)'(fill) + (CL_W+1)'(1) >= (CL_W+1)'(len))
                  && (((next_hist ^ pattern) & mask) == '0);
   end
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         history <= '0;
         fill <= '0;
      end else if (clear) begin
         history <= '0;
         fill <= '0;
      end else if (shift) begin
         history <= next_hist;
`ifdef PATTERN_OVERLAP_EN
         fill <= fill_inc;
`else
         fill <= hit ? '0 : fill_inc;
`endif
      end
endmodule

// File: rtl/pattern_scan_ctrl.sv
// pattern_scan_ctrl: command-driven serial pattern scanner over a bounded frame
// PATTERN_OVERLAP_EN selects overlapping matches inside pattern_window
module pattern_scan_ctrl
   import pattern_scan_pkg::*;
#(
   parameter int PAT_W = DEF_PAT_W,
   parameter int LEN_W = DEF_LEN_W,
   parameter int CNT_W = DEF_CNT_W
) (
   input  logic                         clock,
   input  logic                         reset,
   input  logic                         start,
   input  logic [PAT_W-1:0]             cfg_pattern,
   input  logic [$clog2(PAT_W+1)-1:0]   cfg_len,
   input  logic [LEN_W-1:0]             frame_len,
   input  logic                         bit_valid,
   input  logic                         bit_data,
   output logic                         bit_ready,
   output logic                         busy,
   output logic                         done,
   output logic                         match,
   output logic [CNT_W-1:0]             match_count,
   output logic                         first_found,
   output logic [LEN_W-1:0]             first_idx,
   output logic                         cfg_err
);
   localparam int CL_W = $clog2(PAT_W + 1);
   state_t           state;
   logic [PAT_W-1:0] pattern_q;
   logic [CL_W-1:0]  len_q;
   logic [LEN_W-1:0] frame_q, index;
   logic             accept, hit, last, bad_cfg;
   assign accept = bit_valid & bit_ready;
   assign last = index == frame_q - LEN_W'(1);
   assign bad_cfg = (len_q == '0) || (len_q > CL_W'(PAT_W)) || (frame_q == '0);
   pattern_window #(.PAT_W(PAT_W)) u_window (
      .clock    (clock),
      .reset    (reset),
      .clear    (state == IDLE && start),
      .shift    (accept),
      .bit_data (bit_data),
      .pattern  (pattern_q),
      .len      (len_q),
      .hit      (hit)
   );
   always_ff @(posedge clock or posedge reset)
      if (reset) begin
         state <= IDLE;
         pattern_q <= '0;
         len_q <= '0;
         frame_q <= '0;
         index <= '0;
         bit_ready <= 1'b0;
         busy <= 1'b0;
         done <= 1'b0;
         match <= 1'b0;
         match_count <= '0;
         first_found <= 1'b0;
         first_idx <= '0;
         cfg_err <= 1'b0;
      end else begin
         done <= 1'b0;
         match <= 1'b0;
         case (state)
            IDLE: if (start) begin
               state <= LOAD;
               busy <= 1'b1;
               pattern_q <= cfg_pattern;
               len_q <= cfg_len;
               frame_q <= frame_len;
               index <= '0;
               match_count <= '0;
               first_found <= 1'b0;
               first_idx <= '0;
               cfg_err <= 1'b0;
            end
            LOAD: begin
               state <= bad_cfg ? DONE : SCAN;
               done <= bad_cfg;
               cfg_err <= bad_cfg;
               bit_ready <= !bad_cfg;
            end
            SCAN: if (accept) begin
               match <= hit;
               index <= index + LEN_W'(1);
               if (hit && match_count != '1) match_count <= match_count + CNT_W'(1);
               if (hit && !first_found) begin
                  first_found <= 1'b1;
                  first_idx <= index;
               end
               if (last) begin
                  state <= DONE;
                  done <= 1'b1;
                  bit_ready <= 1'b0;
               end
            end
            DONE: begin
               state <= IDLE;
               busy <= 1'b0;
            end
            default: state <= IDLE;
         endcase
      end
endmodule

// File: tb/tb_pattern_scan_ctrl.sv
// tb_pattern_scan_ctrl: table vectors, corner sequences and random frames against a reference model
module tb_pattern_scan_ctrl;
`ifdef PATTERN_OVERLAP_EN
   localparam int OVL = 1;
`else
   localparam int OVL = 0;
`endif
   logic       clock = 1'b0;
   logic       reset = 1'b1;
   logic       start = 1'b0;
   logic [3:0] cfg_pattern = '0;
   logic [2:0] cfg_len = '0;
   logic [7:0] frame_len = '0;
   logic       bit_valid = 1'b0;
   logic       bit_data = 1'b0;
   logic       bit_ready, busy, done, match, first_found, cfg_err;
   logic [7:0] match_count, first_idx;
   logic       d2_ready, d2_busy, d2_done, d2_match, d2_ff, d2_err;
   logic [1:0] d2_count;
   logic [7:0] d2_idx;
   int checks = 0;
   int errors = 0;

   always #5 clock = ~clock;

   pattern_scan_ctrl dut (
      .clock(clock), .reset(reset), .start(start), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .frame_len(frame_len), .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(bit_ready),
      .busy(busy), .done(done), .match(match), .match_count(match_count),
      .first_found(first_found), .first_idx(first_idx), .cfg_err(cfg_err)
   );

   pattern_scan_ctrl #(.CNT_W(2)) dut2 (
      .clock(clock), .reset(reset), .start(start), .cfg_pattern(cfg_pattern), .cfg_len(cfg_len),
      .frame_len(frame_len), .bit_valid(bit_valid), .bit_data(bit_data), .bit_ready(d2_ready),
      .busy(d2_busy), .done(d2_done), .match(d2_match), .match_count(d2_count),
      .first_found(d2_ff), .first_idx(d2_idx), .cfg_err(d2_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference: a hit is the last len received bits (since the last restart) equalling the pattern
   task automatic run_frame(input logic [3:0] pat, input int len, input int flen,
                            input logic [63:0] bits, input int mode);
      bit err, ff, pend, v;
      int avail, cnt, cnt2, fi, i, cyc;
      bit hits[64];
      err = (len == 0) || (len > 4) || (flen == 0);
      avail = 0; cnt = 0; cnt2 = 0; ff = 0; fi = 0;
      for (int k = 0; k < flen && !err; k++) begin
         bit h;
         avail++;
         h = avail >= len;
         for (int j = 0; j < len && h; j++) if (bits[k-j] != pat[j]) h = 0;
         hits[k] = h;
         if (h) begin
            cnt = cnt < 255 ? cnt + 1 : 255;
            cnt2 = cnt2 < 3 ? cnt2 + 1 : 3;
            if (!ff) begin ff = 1; fi = k; end
            if (OVL == 0) avail = 0;
         end
      end
      @(negedge clock);
      start = 1; cfg_pattern = pat; cfg_len = 3'(len); frame_len = 8'(flen); bit_valid = 0;
      @(posedge clock);
      @(negedge clock);
      start = 0;
      chk("load_busy", busy, 1);
      chk("load_ready", bit_ready, 0);
      chk("load_count_clr", match_count, 0);
      chk("load_err_clr", cfg_err, 0);
      @(posedge clock);
      if (err) begin
         @(negedge clock);
         chk("err_done", done, 1);
         chk("err_flag", cfg_err, 1);
         chk("err_ready", bit_ready, 0);
         chk("err_count", match_count, 0);
         @(negedge clock);
         chk("err_done_end", done, 0);
         chk("err_busy_end", busy, 0);
         chk("err_flag_hold", cfg_err, 1);
         return;
      end
      i = 0; cyc = 0; pend = 0;
      while (i < flen && cyc < 400) begin
         @(negedge clock);
         chk("match", match, 32'(pend));
         chk("scan_ready", bit_ready, 1);
         chk("scan_busy", busy, 1);
         chk("scan_done", done, 0);
         v = mode == 0 ? 1'b1 : mode == 1 ? (cyc % 2) == 1 : $urandom_range(0, 2) != 0;
         start = (cyc % 4) == 3;
         cfg_pattern = 4'($urandom); cfg_len = 3'($urandom); frame_len = 8'($urandom);
         bit_valid = v;
         bit_data = bits[i];
         @(posedge clock);
         pend = 0;
         if (v) begin pend = hits[i]; i++; end
         cyc++;
      end
      chk("scan_bound", i, flen);
      @(negedge clock);
      start = 0; bit_valid = 0;
      chk("end_done", done, 1);
      chk("end_match", match, 32'(pend));
      chk("end_busy", busy, 1);
      chk("end_ready", bit_ready, 0);
      chk("end_count", match_count, cnt);
      chk("end_count2", d2_count, cnt2);
      chk("end_ff", first_found, 32'(ff));
      chk("end_idx", first_idx, fi);
      chk("end_err", cfg_err, 0);
      @(negedge clock);
      chk("idle_done", done, 0);
      chk("idle_busy", busy, 0);
      chk("idle_match", match, 0);
      chk("hold_count", match_count, cnt);
      chk("hold_idx", d2_idx, fi);
   endtask

   typedef struct {
      logic [3:0]  pat;
      int          len;
      int          flen;
      logic [63:0] bits;
      int          mode;
      int          cnt;
      int          cnt2;
      int          idx;
      bit          err;
   } vec_t;
   vec_t tbl[7];

   initial begin
      tbl[0] = '{4'b0011, 3, 7, 64'b1110110, 0, 2, 2, 2, 0};
      tbl[1] = '{4'b0011, 3, 7, 64'b1110110, 1, 2, 2, 2, 0};
      tbl[2] = '{4'b0101, 3, 5, 64'b10101, 0, OVL ? 2 : 1, OVL ? 2 : 1, 2, 0};
      tbl[3] = '{4'b0000, 0, 0, 64'b0, 0, 0, 0, 0, 1};
      tbl[4] = '{4'b0110, 5, 3, 64'b111, 0, 0, 0, 0, 1};
      tbl[5] = '{4'b0001, 1, 0, 64'b1, 0, 0, 0, 0, 1};
      tbl[6] = '{4'b0001, 1, 5, 64'b11111, 1, 5, 3, 0, 0};
      repeat (2) @(negedge clock);
      chk("rst_busy", busy, 0);
      chk("rst_ready", bit_ready, 0);
      chk("rst_count", match_count, 0);
      chk("rst_done", done, 0);
      reset = 0;
      for (int t = 0; t < 7; t++) begin
         run_frame(tbl[t].pat, tbl[t].len, tbl[t].flen, tbl[t].bits, tbl[t].mode);
         chk("tbl_count", match_count, tbl[t].cnt);
         chk("tbl_count2", d2_count, tbl[t].cnt2);
         chk("tbl_idx", first_idx, tbl[t].idx);
         chk("tbl_err", cfg_err, 32'(tbl[t].err));
      end
      // Abort a frame after three accepted bits
      @(negedge clock);
      start = 1; cfg_pattern = 4'b0001; cfg_len = 1; frame_len = 10;
      @(posedge clock);
      @(negedge clock);
      start = 0; bit_valid = 1; bit_data = 1;
      repeat (4) @(posedge clock);
      @(negedge clock);
      chk("pre_rst_count", match_count, 3);
      reset = 1;
      #1;
      chk("rst_mid_busy", busy, 0);
      chk("rst_mid_ready", bit_ready, 0);
      chk("rst_mid_match", match, 0);
      chk("rst_mid_count", match_count, 0);
      chk("rst_mid_ff", first_found, 0);
      chk("rst_mid_done", done, 0);
      @(negedge clock);
      reset = 0; bit_valid = 0;
      run_frame(4'b0011, 3, 7, 64'b1110110, 0);
      chk("post_rst_count", match_count, 2);
      for (int r = 0; r < 40; r++) begin
         int len, flen;
         len = $urandom_range(0, 9);
         if (len > 5) len = $urandom_range(1, 4);
         flen = $urandom_range(0, 7) == 0 ? 0 : $urandom_range(1, 60);
         run_frame(4'($urandom), len, flen, {$urandom, $urandom}, 2);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/pattern_scan_ctrl.md
Name: pattern_scan_ctrl

Overview:
Controller that sequences a serial bit stream through a programmable pattern detector for a bounded frame.
- Accepts a start command with pattern configuration and frame length.
- Pulls frame bits over a valid/ready handshake.
- Reports per-bit match pulses, a saturating match count and the index of the first match.
- Generalises the fixed serial Mealy pattern detectors in the warmup area into a reusable, command-driven scanner.

Parameters:
PAT_W, 4, maximum pattern length in bits (>=1)
LEN_W, 8, width of frame length and bit index
CNT_W, 8, width of the saturating match counter

Ports:
clock  in  1  system clock; all state updates on rising edge
reset  in  1  asynchronous, active-high reset
start  in  1  command strobe; sampled only in IDLE
cfg_pattern  in  PAT_W  pattern; bit [cfg_len-1] is the first bit received, bit 0 the last
cfg_len  in  $clog2(PAT_W+1)  active pattern length
frame_len  in  LEN_W  number of bits to scan
bit_valid  in  1  source has a bit
bit_data  in  1  serial bit
bit_ready  out  1  controller accepts a bit this cycle
busy  out  1  command in progress
done  out  1  one-cycle completion pulse
match  out  1  one-cycle pulse, registered
match_count  out  CNT_W  matches in current/last frame
first_found  out  1  at least one match this frame
first_idx  out  LEN_W  0-based index of the bit completing the first match
cfg_err  out  1  last command rejected

Behaviour:
- Reset (asynchronous): state=IDLE; all outputs 0; history, fill, index and latched configuration cleared. Reset mid-frame aborts with no done pulse.
- FSM states: IDLE, LOAD, SCAN, DONE.
- IDLE:
  - busy=0, bit_ready=0.
  - start=1 → LOAD. Latches cfg_pattern, cfg_len, frame_len; clears match_count, first_found, first_idx, cfg_err, history, fill, index.
- LOAD: busy=1, one cycle.
  - If cfg_len==0, cfg_len>PAT_W or frame_len==0 → DONE with cfg_err=1.
  - Otherwise → SCAN.
- SCAN: busy=1, bit_ready=1. Each accepted bit (bit_valid & bit_ready):
  - history = {history[PAT_W-2:0], bit_data}.
  - fill increments and saturates at PAT_W.
  - hit when (fill+1)>=cfg_len and the new history[cfg_len-1:0]==pattern[cfg_len-1:0].
  - hit → match=1 next cycle.
  - hit → match_count increments, saturating at 2^CNT_W-1.
  - On the first hit of the frame: first_found=1 and first_idx=index.
  - index increments. The accepted bit with index==frame_len-1 → DONE.
  - bit_valid=0 → no change; there is no timeout.
- DONE: busy=1, done=1 for exactly one cycle → IDLE.
- Latency:
  - start sampled at edge 0 → LOAD during cycle 1, SCAN (bit_ready=1) from cycle 2.
  - Last bit accepted at edge N → done=1 and that bit's match=1 in the same cycle after edge N.
- start while busy is ignored.
- Results hold from DONE until the next accepted start.
- match is 0 outside the cycle following a hit.

Optional Feature:
PATTERN_OVERLAP_EN
- Defined: history and fill are retained after a hit, so overlapping matches count.
- Undefined: a hit clears fill to 0, giving non-overlapping matching; the next match needs cfg_len fresh bits.

Decomposition:
- Package pattern_scan_pkg: state enum typedef (IDLE/LOAD/SCAN/DONE), default widths, saturation max constant.
- Sub-module pattern_window: history shift register, fill counter, masked compare producing hit. It is parameterised by PAT_W and honours the overlap macro.
- Controller holds the FSM, counters and handshake.

Test Plan:
- Pattern 3'b011, len 3, frame 7, stream 0,1,1,0,1,1,1 with bit_valid held high → match pulses after bits 2 and 5; match_count=2; first_idx=2; done 1 cycle after bit 6; busy low the cycle after done.
- Pattern 3'b101, len 3, stream 1,0,1,0,1 → count 2 with PATTERN_OVERLAP_EN, count 1 without.
- Backpressure: same as test 1 with bit_valid low on alternating cycles → identical counts and indices; bit_ready stays high in SCAN.
- cfg_len=0 (also frame_len=0) → done pulses in cycle 2 after start; cfg_err=1; match_count=0; no bit_ready.
- CNT_W=2, pattern 1'b1, len 1, frame 5 all ones → match_count saturates at 3, first_idx=0; start pulses during SCAN ignored.
- Reset asserted mid-frame (after 3 bits) → all outputs 0 immediately, IDLE; a fresh start runs a normal frame with counters from 0.
